call_stack: RTL

//  Clocked, parametrised return-address stack for the MUSA core. Replaces the

---
 rtl/musa_pkg.sv | 14 +
 rtl/call_stack_mem.sv | 28 ++
 rtl/call_stack.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/musa_pkg.sv
// Shared MUSA core definitions: PC width and the decoded return-stack operation.
package musa_pkg;

    localparam int PC_W = 18;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPL,
        OP_FLUSH
    } stack_op_e;

endpackage

// File: rtl/call_stack_mem.sv
// DEPTH x WIDTH register file for the return stack: one write port, one
// asynchronous read port, contents not reset.
module call_stack_mem
    import musa_pkg::*;
#(
    parameter int WIDTH = PC_W,
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/call_stack.sv
// Clocked return-address stack with count/full/empty status, error pulses and flush.
// Define CALL_STACK_WRAP_EN to make the stack circular (push while full drops the oldest entry).
module call_stack
    import musa_pkg::*;
#(
    parameter int   WIDTH = PC_W,
    parameter int   DEPTH = 16,
    localparam int  CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W:0] DEPTH_X = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Physical slot of logical entry 'off' above the base; off never exceeds DEPTH.
    function automatic logic [PTR_W-1:0] slot(input logic [PTR_W-1:0] base,
                                              input logic [CNT_W-1:0] off);
        logic [CNT_W:0] s;
        s = (CNT_W + 1)'(base) + (CNT_W + 1)'(off);
        if (s >= DEPTH_X) begin
            s = s - DEPTH_X;
        end
        return s[PTR_W-1:0];
    endfunction

    stack_op_e        op;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] top_q, top_d;
    logic [PTR_W-1:0] base_q, base_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             mem_we;
    logic [PTR_W-1:0] mem_waddr;
    logic [PTR_W-1:0] mem_raddr;
    logic [WIDTH-1:0] mem_rdata;

    call_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (push_data),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // push & pop on an empty stack decodes as a plain push.
    always_comb begin
        op = OP_NONE;
        if (flush) begin
            op = OP_FLUSH;
        end else if (push && pop && !empty_q) begin
            op = OP_REPL;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end
    end

    // The entry beneath the top, which becomes the new top on a pop.
    assign mem_raddr = (count_q >= CNT_W'(2)) ? slot(base_q, count_q - CNT_W'(2)) : base_q;

    always_comb begin
        count_d   = count_q;
        top_d     = top_q;
        base_d    = base_q;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = slot(base_q, count_q);
        unique case (op)
            OP_FLUSH: begin
                count_d = '0;
                top_d   = '0;
                base_d  = '0;
            end
            OP_REPL: begin
                mem_we    = 1'b1;
                mem_waddr = slot(base_q, count_q - CNT_W'(1));
                top_d     = push_data;
            end
            OP_PUSH: begin
                if (!full_q) begin
                    mem_we  = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    top_d   = push_data;
                end else begin
                    ovf_d = 1'b1;
`ifdef CALL_STACK_WRAP_EN
                    // The oldest slot becomes the newest once the base moves past it.
                    mem_we    = 1'b1;
                    mem_waddr = base_q;
                    base_d    = slot(base_q, CNT_W'(1));
                    top_d     = push_data;
`endif
                end
            end
            OP_POP: begin
                if (empty_q) begin
                    unf_d = 1'b1;
                end else begin
                    count_d = count_q - CNT_W'(1);
                    top_d   = (count_q == CNT_W'(1)) ? '0 : mem_rdata;
                end
            end
            default: ;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            top_q   <= '0;
            base_q  <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            top_q   <= top_d;
            base_q  <= base_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign top_data  = top_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
